// File: rtl/adam_aes_bus_driver.sv
// Bus initiator for the AES register peripheral. One accepted request becomes a
// fixed sequence of register accesses: configuration, eight key words, four block
// words, clearing a stale done event, start, polling for done, acknowledging it
// and reading back four result words. A poll timeout skips the acknowledge and
// read-back and returns a zero result flagged by out_timeout.
module adam_aes_bus_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 13
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_encdec,
  input  logic         in_keylen,
  input  logic [255:0] in_key,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_result,
  output logic         out_timeout,
  output logic         busy,
  output logic         bus_cs,
  output logic         bus_we,
  output logic [7:0]   bus_address,
  output logic [31:0]  bus_write_data,
  input  logic [31:0]  bus_read_data
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG,
    S_KEY,
    S_BLK,
    S_CLR0,
    S_START,
    S_WAIT,
    S_ACK,
    S_RES,
    S_DONE
  } state_t;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_CONFIG = 8'h08;
  localparam logic [7:0] ADDR_EVENT  = 8'h0C;
  localparam logic [7:0] ADDR_KEY    = 8'h14;
  localparam logic [7:0] ADDR_BLOCK  = 8'h18;
  localparam logic [7:0] ADDR_RESULT = 8'h1C;

  // Poll index of the last permitted WAIT read; only meaningful when a timeout is set.
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] POLL_MAX  = '1;
  localparam bit               USE_TIMEOUT = (TIMEOUT_CYCLES != 0);

  state_t           state_q,    state_d;
  logic [2:0]       wordCnt_q,  wordCnt_d;
  logic [CNT_W-1:0] pollCnt_q,  pollCnt_d;
  logic [255:0]     key_q,      key_d;
  logic [127:0]     block_q,    block_d;
  logic             encdec_q,   encdec_d;
  logic             keylen_q,   keylen_d;
  logic [127:0]     result_q,   result_d;
  logic             timeout_q,  timeout_d;
  logic             outValid_q, outValid_d;
  logic             inReady_q,  inReady_d;
  logic             busCs_q,    busCs_d;
  logic             busWe_q,    busWe_d;
  logic [7:0]       busAddr_q,  busAddr_d;
  logic [31:0]      busWdata_q, busWdata_d;

  // Sequencing: next state, word/poll counters, request capture and result assembly.
  always_comb begin
    state_d   = state_q;
    wordCnt_d = wordCnt_q;
    pollCnt_d = pollCnt_q;
    key_d     = key_q;
    block_d   = block_q;
    encdec_d  = encdec_q;
    keylen_d  = keylen_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && inReady_q) begin
          state_d   = S_CFG;
          key_d     = in_key;
          block_d   = in_block;
          encdec_d  = in_encdec;
          keylen_d  = in_keylen;
          result_d  = '0;
          timeout_d = 1'b0;
        end
      end
      S_CFG: begin
        state_d   = S_KEY;
        wordCnt_d = '0;
      end
      S_KEY: begin
        if (wordCnt_q == 3'd7) begin
          state_d   = S_BLK;
          wordCnt_d = '0;
        end else begin
          wordCnt_d = wordCnt_q + 3'd1;
        end
      end
      S_BLK: begin
        if (wordCnt_q == 3'd3) begin
          state_d = S_CLR0;
        end else begin
          wordCnt_d = wordCnt_q + 3'd1;
        end
      end
      S_CLR0: begin
        state_d = S_START;
      end
      S_START: begin
        state_d   = S_WAIT;
        pollCnt_d = '0;
      end
      S_WAIT: begin
        if (bus_read_data[0]) begin
          state_d = S_ACK;
        end else if (USE_TIMEOUT && (pollCnt_q == POLL_LAST)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
          result_d  = '0;
        end else if (pollCnt_q != POLL_MAX) begin
          pollCnt_d = pollCnt_q + 1'b1;
        end
      end
      S_ACK: begin
        state_d   = S_RES;
        wordCnt_d = '0;
      end
      S_RES: begin
        result_d[{~wordCnt_q[1:0], 5'b0} +: 32] = bus_read_data;
        if (wordCnt_q == 3'd3) begin
          state_d = S_DONE;
        end else begin
          wordCnt_d = wordCnt_q + 3'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d   = S_IDLE;
          result_d  = '0;
          timeout_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus command for the state being entered, so each access appears in its first cycle.
  always_comb begin
    busCs_d    = 1'b0;
    busWe_d    = 1'b0;
    busAddr_d  = '0;
    busWdata_d = '0;
    outValid_d = (state_d == S_DONE);
    inReady_d  = (state_d == S_IDLE);
    case (state_d)
      S_CFG: begin
        busCs_d    = 1'b1;
        busWe_d    = 1'b1;
        busAddr_d  = ADDR_CONFIG;
        busWdata_d = {30'b0, keylen_d, encdec_d};
      end
      S_KEY: begin
        busCs_d    = 1'b1;
        busWe_d    = 1'b1;
        busAddr_d  = ADDR_KEY;
        busWdata_d = key_d[{~wordCnt_d, 5'b0} +: 32];
      end
      S_BLK: begin
        busCs_d    = 1'b1;
        busWe_d    = 1'b1;
        busAddr_d  = ADDR_BLOCK;
        busWdata_d = block_d[{~wordCnt_d[1:0], 5'b0} +: 32];
      end
      S_CLR0, S_ACK: begin
        busCs_d    = 1'b1;
        busWe_d    = 1'b1;
        busAddr_d  = ADDR_EVENT;
        busWdata_d = 32'h1;
      end
      S_START: begin
        busCs_d    = 1'b1;
        busWe_d    = 1'b1;
        busAddr_d  = ADDR_CTRL;
        busWdata_d = 32'h3;
      end
      S_WAIT: begin
        busCs_d   = 1'b1;
        busAddr_d = ADDR_EVENT;
      end
      S_RES: begin
        busCs_d   = 1'b1;
        busAddr_d = ADDR_RESULT;
      end
      default: begin
        busCs_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wordCnt_q  <= '0;
      pollCnt_q  <= '0;
      key_q      <= '0;
      block_q    <= '0;
      encdec_q   <= 1'b0;
      keylen_q   <= 1'b0;
      result_q   <= '0;
      timeout_q  <= 1'b0;
      outValid_q <= 1'b0;
      inReady_q  <= 1'b0;
      busCs_q    <= 1'b0;
      busWe_q    <= 1'b0;
      busAddr_q  <= '0;
      busWdata_q <= '0;
    end else begin
      state_q    <= state_d;
      wordCnt_q  <= wordCnt_d;
      pollCnt_q  <= pollCnt_d;
      key_q      <= key_d;
      block_q    <= block_d;
      encdec_q   <= encdec_d;
      keylen_q   <= keylen_d;
      result_q   <= result_d;
      timeout_q  <= timeout_d;
      outValid_q <= outValid_d;
      inReady_q  <= inReady_d;
      busCs_q    <= busCs_d;
      busWe_q    <= busWe_d;
      busAddr_q  <= busAddr_d;
      busWdata_q <= busWdata_d;
    end
  end

  assign in_ready       = inReady_q;
  assign out_valid      = outValid_q;
  assign out_result     = result_q;
  assign out_timeout    = timeout_q;
  assign busy           = (state_q != S_IDLE);
  assign bus_cs         = busCs_q;
  assign bus_we         = busWe_q;
  assign bus_address    = busAddr_q;
  assign bus_write_data = busWdata_q;

endmodule
